// File: rtl/usart_tx_arbiter.sv
// Round-robin byte arbiter sharing one usart_tx between NUM_PORTS requesters.
// A requester may lock the grant across bytes; an idle lock can time out.
module usart_tx_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   comm_clock,
  input  logic                   reset,
  input  logic [8*NUM_PORTS-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [NUM_PORTS-1:0]   req_lock,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic [NUM_PORTS-1:0]   grant,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        owner, owner_n;
  logic [PW-1:0]        ptr, ptr_n;
  logic [PW-1:0]        sel, cand, next_ptr;
  logic                 found;
  logic [NUM_PORTS-1:0] grant_n, ready_n;
  logic [7:0]           data_n;
  logic                 valid_n;
  logic [CW-1:0]        cnt, cnt_n;

  // Scan from ptr upward with wrap; cand stays below NUM_PORTS.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ptr >= PW'(NUM_PORTS - i))
        cand = ptr - PW'(NUM_PORTS - i);
      else
        cand = ptr + PW'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign next_ptr = (owner == LAST_PORT) ? '0 : owner + 1'b1;

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    grant_n = grant;
    ready_n = '0;
    data_n  = tx_data;
    valid_n = tx_valid;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_n      = sel;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          data_n       = req_data[{sel, 3'b000} +: 8];
          valid_n      = 1'b1;
          state_n      = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          valid_n        = 1'b0;
          ready_n[owner] = 1'b1;
          state_n        = GAP;
        end
      end
      GAP: begin
        if (req_lock[owner]) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          grant_n = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (req_valid[owner]) begin
          data_n  = req_data[{owner, 3'b000} +: 8];
          valid_n = 1'b1;
          state_n = SEND;
        end else if (!req_lock[owner] ||
                     (LOCK_TIMEOUT != 0 && cnt == CNT_LAST)) begin
          grant_n = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      grant     <= '0;
      req_ready <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      grant     <= grant_n;
      req_ready <= ready_n;
      tx_data   <= data_n;
      tx_valid  <= valid_n;
      cnt       <= cnt_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Bench for usart_tx_arbiter: vector table, scoreboard runs, corner sequences.
// Two instances share stimulus: one with a 16-cycle lock timeout, one with none.
module tb_usart_tx_arbiter;

  localparam int N = 4;

  logic           comm_clock = 1'b0;
  logic           reset = 1'b1;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic           tx_ready = 1'b0;

  logic [N-1:0]   req_ready, grant;
  logic [7:0]     tx_data;
  logic           tx_valid, busy;

  logic [N-1:0]   z_ready, z_grant;
  logic [7:0]     z_data;
  logic           z_valid, z_busy;

  int tests = 0;
  int fails = 0;

  always #5 comm_clock = ~comm_clock;

  usart_tx_arbiter #(.NUM_PORTS(N), .LOCK_TIMEOUT(16)) dut (
    .comm_clock(comm_clock), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_lock(req_lock),
    .req_ready(req_ready), .grant(grant),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  usart_tx_arbiter #(.NUM_PORTS(N), .LOCK_TIMEOUT(0)) dut_nt (
    .comm_clock(comm_clock), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_lock(req_lock),
    .req_ready(z_ready), .grant(z_grant),
    .tx_data(z_data), .tx_valid(z_valid), .tx_ready(tx_ready),
    .busy(z_busy)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] lock;
    logic         rdy;
    logic [N-1:0] e_grant;
    logic         e_valid;
    logic [7:0]   e_data;
    logic [N-1:0] e_ready;
    logic         e_busy;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   total[N];
  int   sent[N];
  logic [N-1:0] lock_en;

  task automatic tick();
    @(posedge comm_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    tx_ready  = 1'b0;
    req_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t v(
    input logic [N-1:0] valid, input logic [N-1:0] lock,
    input logic rdy, input logic [N-1:0] e_grant,
    input logic e_valid, input logic [7:0] e_data,
    input logic [N-1:0] e_ready, input logic e_busy);
    vec_t r;
    r.valid = valid;     r.lock = lock;       r.rdy = rdy;
    r.e_grant = e_grant; r.e_valid = e_valid; r.e_data = e_data;
    r.e_ready = e_ready; r.e_busy = e_busy;
    return r;
  endfunction

  function automatic exp_t ex(input int port, input logic [7:0] data);
    exp_t r;
    r.port = port;
    r.data = data;
    return r;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (sent[i] < total[i]);
      req_lock[i]  = lock_en[i] && (sent[i] < total[i]);
      req_data[i*8 +: 8] = {4'(i), 4'(sent[i])};
    end
  endtask

  // Requesters hold bytes until their ready pulse; the transmitter
  // answers each byte with a one-cycle tx_ready after three cycles.
  task automatic run(input int max_cyc, output int acq);
    logic [7:0]   cap_data;
    logic [N-1:0] cap_grant;
    logic [N-1:0] oh;
    logic         prev_tv;
    logic         prev_g;
    int           wait_n;
    exp_t         e;
    acq       = 0;
    wait_n    = 0;
    prev_tv   = 1'b0;
    prev_g    = 1'b0;
    cap_data  = '0;
    cap_grant = '0;
    tx_ready  = 1'b0;
    drive_reqs();
    for (int c = 0; c < max_cyc && sb.size() > 0; c++) begin
      tick();
      if (grant != '0 && !prev_g) acq++;
      prev_g = (grant != '0);
      if (tx_valid && !prev_tv) begin
        cap_data  = tx_data;
        cap_grant = grant;
      end
      prev_tv = tx_valid;
      if (req_ready != '0) begin
        chk("ready_is_owner", req_ready, cap_grant);
        e  = sb.pop_front();
        oh = '0;
        oh[e.port] = 1'b1;
        chk("ready_port", req_ready, oh);
        chk("byte_data", cap_data, e.data);
        for (int i = 0; i < N; i++)
          if (req_ready[i]) sent[i]++;
      end
      drive_reqs();
      if (tx_ready) begin
        tx_ready = 1'b0;
      end else if (tx_valid) begin
        if (wait_n == 2) begin
          tx_ready = 1'b1;
          wait_n   = 0;
        end else begin
          wait_n++;
        end
      end
    end
    tx_ready = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  int           acq;
  int           bad;
  logic [N-1:0] exp_g;

  initial begin
    // Table: {valid, lock, tx_ready} -> {grant, tx_valid, data, ready, busy}
    vt.push_back(v(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b0100, 4'b0000, 0, 4'b0100, 1, 8'hA5, 4'b0000, 1));
    vt.push_back(v(4'b0100, 4'b0000, 0, 4'b0100, 1, 8'hA5, 4'b0000, 1));
    vt.push_back(v(4'b0110, 4'b0000, 0, 4'b0100, 1, 8'hA5, 4'b0000, 1));
    vt.push_back(v(4'b0100, 4'b0000, 1, 4'b0100, 0, 8'h00, 4'b0100, 1));
    vt.push_back(v(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b1001, 4'b0000, 0, 4'b1000, 1, 8'hC3, 4'b0000, 1));
    vt.push_back(v(4'b1001, 4'b0000, 1, 4'b1000, 0, 8'h00, 4'b1000, 1));
    vt.push_back(v(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b0011, 4'b0000, 0, 4'b0001, 1, 8'hC0, 4'b0000, 1));
    vt.push_back(v(4'b0011, 4'b0000, 1, 4'b0001, 0, 8'h00, 4'b0001, 1));
    vt.push_back(v(4'b0010, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b0000, 4'b0010, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    vt.push_back(v(4'b0101, 4'b0000, 0, 4'b0100, 1, 8'hA5, 4'b0000, 1));
    vt.push_back(v(4'b0101, 4'b0000, 1, 4'b0100, 0, 8'h00, 4'b0100, 1));
    vt.push_back(v(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));

    do_reset();
    chk("reset_grant", grant, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_nt_grant", z_grant, 0);

    req_data = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
    foreach (vt[i]) begin
      req_valid = vt[i].valid;
      req_lock  = vt[i].lock;
      tx_ready  = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d grant", i), grant, vt[i].e_grant);
      chk($sformatf("vec%0d tx_valid", i), tx_valid, vt[i].e_valid);
      if (vt[i].e_valid)
        chk($sformatf("vec%0d tx_data", i), tx_data, vt[i].e_data);
      chk($sformatf("vec%0d req_ready", i), req_ready, vt[i].e_ready);
      chk($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d nt_grant", i), z_grant, vt[i].e_grant);
    end

    // Round robin with wrap across ports 0, 1, 3.
    do_reset();
    total   = '{2, 2, 0, 2};
    sent    = '{0, 0, 0, 0};
    lock_en = '0;
    sb.push_back(ex(0, 8'h00)); sb.push_back(ex(1, 8'h10));
    sb.push_back(ex(3, 8'h30)); sb.push_back(ex(0, 8'h01));
    sb.push_back(ex(1, 8'h11)); sb.push_back(ex(3, 8'h31));
    run(300, acq);
    chk("rr_acquisitions", acq, 6);

    // Locked burst from port 1 while port 0 waits.
    do_reset();
    total   = '{1, 0, 0, 0};
    sent    = '{0, 0, 0, 0};
    lock_en = '0;
    sb.push_back(ex(0, 8'h00));
    run(100, acq);
    total   = '{2, 3, 0, 0};
    lock_en = 4'b0010;
    sb.push_back(ex(1, 8'h10)); sb.push_back(ex(1, 8'h11));
    sb.push_back(ex(1, 8'h12)); sb.push_back(ex(0, 8'h01));
    run(300, acq);
    chk("lock_acquisitions", acq, 2);

    // Lock timeout on port 3 with port 0 pending.
    do_reset();
    req_data  = {8'h3A, 8'h00, 8'h00, 8'h5C};
    req_valid = 4'b1000;
    req_lock  = 4'b1000;
    tick();
    chk("to_grant3", grant, 4'b1000);
    chk("to_data3", tx_data, 8'h3A);
    tx_ready = 1'b1;
    tick();
    chk("to_ready3", req_ready, 4'b1000);
    tx_ready  = 1'b0;
    req_valid = 4'b0001;
    tick();
    chk("to_hold_grant", grant, 4'b1000);
    chk("to_hold_busy", busy, 1);
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (grant !== 4'b1000) bad++;
    end
    chk("to_held_15", bad, 0);
    tick();
    chk("to_release_grant", grant, 0);
    chk("to_release_busy", busy, 0);
    chk("nt_still_held", z_grant, 4'b1000);
    tick();
    chk("to_next_grant", grant, 4'b0001);
    chk("to_next_data", tx_data, 8'h5C);
    chk("to_next_valid", tx_valid, 1);
    chk("nt_still_held2", z_grant, 4'b1000);
    req_lock = 4'b0000;
    tick();
    chk("nt_release_grant", z_grant, 0);
    chk("nt_release_busy", z_busy, 0);
    tick();
    chk("nt_next_grant", z_grant, 4'b0001);

    // Lock dropped in HOLD, no timeout: pointer moves to port 2.
    do_reset();
    req_data  = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    tick();
    chk("nl_grant1", z_grant, 4'b0010);
    tx_ready = 1'b1;
    tick();
    chk("nl_ready1", z_ready, 4'b0010);
    tx_ready  = 1'b0;
    req_valid = 4'b0101;
    tick();
    tick(); tick(); tick();
    chk("nl_held", z_grant, 4'b0010);
    chk("nl_held_to", grant, 4'b0010);
    req_lock = 4'b0000;
    tick();
    chk("nl_release", z_grant, 0);
    chk("nl_release_busy", z_busy, 0);
    tick();
    chk("nl_next_grant", z_grant, 4'b0100);
    chk("nl_next_data", z_data, 8'hA5);

    // Reset while port 2 is mid-send; pointer returns to 0.
    do_reset();
    req_data  = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
    req_valid = 4'b0100;
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready  = 1'b0;
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    tick();
    chk("rs_sending", tx_valid, 1);
    exp_g = 4'b0100;
    chk("rs_grant2", grant, exp_g);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_tx_valid", tx_valid, 0);
    chk("rs_grant", grant, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", req_ready, 0);
    req_valid = 4'b0000;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("rs_late_ready", req_ready, 0);
    chk("rs_late_valid", tx_valid, 0);
    req_valid = 4'b1001;
    tick();
    chk("rs_ptr_zero", grant, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
